// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds and fill-level output.
// Optional sticky overflow/underflow flags are compiled in when FIFO_ERR_FLAGS_EN is defined.
module fifo_sync_prog #(
  parameter int width     = 16,
  parameter int depth     = 8,
  parameter int adr_width = $clog2(depth),
  parameter int af_level  = depth - 2,
  parameter int ae_level  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [width-1:0]   data_in,
  output logic [width-1:0]   data_out,
  output logic               rd_valid,
  output logic               FIFO_full,
  output logic               FIFO_empty,
  output logic               FIFO_almost_full,
  output logic               FIFO_almost_empty,
  output logic [adr_width:0] fill_level
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic               err_clr,
  output logic               FIFO_overflow,
  output logic               FIFO_underflow
`endif
);

  localparam logic [adr_width:0] depth_lv = (adr_width + 1)'(depth);
  localparam logic [adr_width:0] af_lv    = (adr_width + 1)'(af_level);
  localparam logic [adr_width:0] ae_lv    = (adr_width + 1)'(ae_level);
  localparam logic [adr_width:0] one_lv   = (adr_width + 1)'(1);

  logic [width-1:0]   mem [depth];
  logic [adr_width:0] wr_ptr;
  logic [adr_width:0] rd_ptr;
  logic               wr_acc;
  logic               rd_acc;

  // Requests are single-cycle strobes with no back-pressure stall: a request is
  // taken on the edge only when the registered flag allows it (not full for
  // writes, not empty for reads), otherwise it is dropped and the requester must
  // retry; an accepted read returns data_out with rd_valid one cycle later.
  always_comb begin
    wr_acc = wr_en & ~FIFO_full;
    rd_acc = rd_en & ~FIFO_empty;
  end

  // Flags are pure decodes of the registered occupancy.
  always_comb begin
    FIFO_full         = (fill_level == depth_lv);
    FIFO_empty        = (fill_level == '0);
    FIFO_almost_full  = (fill_level >= af_lv);
    FIFO_almost_empty = (fill_level <= ae_lv);
  end

  // Storage is never reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr[adr_width-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (wr_acc) begin
      wr_ptr <= wr_ptr + one_lv;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + one_lv;
        data_out <= mem[rd_ptr[adr_width-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_level <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   fill_level <= fill_level + one_lv;
        2'b01:   fill_level <= fill_level - one_lv;
        default: fill_level <= fill_level;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // A new error on the same edge outranks the clear so it is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      FIFO_overflow  <= 1'b0;
      FIFO_underflow <= 1'b0;
    end else begin
      if (wr_en && FIFO_full) begin
        FIFO_overflow <= 1'b1;
      end else if (err_clr) begin
        FIFO_overflow <= 1'b0;
      end
      if (rd_en && FIFO_empty) begin
        FIFO_underflow <= 1'b1;
      end else if (err_clr) begin
        FIFO_underflow <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench for fifo_sync_prog (width=16, depth=8, af=6, ae=1) with a queue scoreboard.
// Define FIFO_ERR_FLAGS_EN for both bench and RTL to exercise the sticky error flags.
module tb_fifo_sync_prog;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         rd_valid;
  logic         FIFO_full;
  logic         FIFO_empty;
  logic         FIFO_almost_full;
  logic         FIFO_almost_empty;
  logic [3:0]   fill_level;
`ifdef FIFO_ERR_FLAGS_EN
  logic         err_clr;
  logic         FIFO_overflow;
  logic         FIFO_underflow;
`endif

  fifo_sync_prog #(
    .width(16), .depth(8), .af_level(6), .ae_level(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .data_in(data_in),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .FIFO_full(FIFO_full),
    .FIFO_empty(FIFO_empty),
    .FIFO_almost_full(FIFO_almost_full),
    .FIFO_almost_empty(FIFO_almost_empty),
    .fill_level(fill_level)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .err_clr(err_clr),
    .FIFO_overflow(FIFO_overflow),
    .FIFO_underflow(FIFO_underflow)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_data;
  logic         exp_valid;
  int           total_cnt;
  int           pass_cnt;
  int           max_fill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, ".fill_level"}, 32'(fill_level), 32'(n));
    chk({tag, ".empty"}, 32'(FIFO_empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(FIFO_full), 32'(n == D));
    chk({tag, ".almost_full"}, 32'(FIFO_almost_full), 32'(n >= 6));
    chk({tag, ".almost_empty"}, 32'(FIFO_almost_empty), 32'(n <= 1));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_valid));
    chk({tag, ".data_out"}, 32'(data_out), 32'(exp_data));
  endtask

  // Driver: one clock with the given requests, model updated from pre-edge occupancy.
  task automatic step(input logic w, input logic r, input logic [W-1:0] d);
    logic wacc;
    logic racc;
    wacc = w && (exp_q.size() < D);
    racc = r && (exp_q.size() > 0);
    wr_en = w;
    rd_en = r;
    data_in = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    exp_valid = racc;
    if (racc) exp_data = exp_q.pop_front();
    if (wacc) exp_q.push_back(d);
    if (exp_q.size() > max_fill) max_fill = exp_q.size();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_data = '0;
    exp_valid = 1'b0;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt = 0;
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    data_in = '0;
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    exp_data = '0;
    exp_valid = 1'b0;
    @(posedge clk);
    do_reset();
    check_state("reset");

    // 1: fill 0x0001..0x0008
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, W'(i));
      check_state("fill");
    end
    chk("fill.full_hand", 32'(FIFO_full), 32'd1);
    chk("fill.level_hand", 32'(fill_level), 32'd8);

    // 2: drain in order
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, '0);
      check_state("drain");
      chk("drain.data_hand", 32'(data_out), 32'(i));
    end
    chk("drain.empty_hand", 32'(FIFO_empty), 32'd1);

    // 3: bursts of 5 through pointer wrap
    max_fill = 0;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 5; k++) begin
        step(1'b1, 1'b0, W'(16'h1000 + b * 5 + k));
        check_state("wrap_wr");
      end
      for (int k = 0; k < 5; k++) begin
        step(1'b0, 1'b1, '0);
        check_state("wrap_rd");
        chk("wrap.data_hand", 32'(data_out), 32'(16'h1000 + b * 5 + k));
      end
    end
    chk("wrap.max_fill", 32'(max_fill), 32'd5);

    // 4: simultaneous read/write at full and at empty
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, W'(16'hA0 + i));
    step(1'b1, 1'b1, 16'hDEAD);
    check_state("full_rw");
    chk("full_rw.data_hand", 32'(data_out), 32'h00A0);
    chk("full_rw.level_hand", 32'(fill_level), 32'd7);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, '0);
    chk("pre_empty.data_hand", 32'(data_out), 32'h00A7);
    step(1'b1, 1'b1, 16'h1234);
    check_state("empty_rw");
    chk("empty_rw.rd_valid_hand", 32'(rd_valid), 32'd0);
    chk("empty_rw.level_hand", 32'(fill_level), 32'd1);
    step(1'b0, 1'b1, '0);
    check_state("empty_rw_rd");
    chk("empty_rw_rd.data_hand", 32'(data_out), 32'h1234);

    // 5: reset mid-operation at fill_level 5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'(16'h5500 + i));
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 16'h5505);
    chk("pre_reset.level_hand", 32'(fill_level), 32'd5);
    do_reset();
    check_state("mid_reset");
    chk("mid_reset.data_hand", 32'(data_out), 32'h0000);
    step(1'b1, 1'b0, 16'hBEEF);
    check_state("post_reset_wr");
    step(1'b0, 1'b1, '0);
    check_state("post_reset_rd");
    chk("post_reset.data_hand", 32'(data_out), 32'hBEEF);

`ifdef FIFO_ERR_FLAGS_EN
    // 6: sticky error flags
    chk("err.ovf_init", 32'(FIFO_overflow), 32'd0);
    chk("err.unf_init", 32'(FIFO_underflow), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, W'(i));
    step(1'b1, 1'b0, 16'hFFFF);
    check_state("err_ovf");
    chk("err.ovf_set", 32'(FIFO_overflow), 32'd1);
    step(1'b0, 1'b0, '0);
    chk("err.ovf_held", 32'(FIFO_overflow), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
    chk("err.unf_before", 32'(FIFO_underflow), 32'd0);
    step(1'b0, 1'b1, '0);
    check_state("err_unf");
    chk("err.unf_set", 32'(FIFO_underflow), 32'd1);
    step(1'b0, 1'b0, '0);
    chk("err.unf_held", 32'(FIFO_underflow), 32'd1);
    chk("err.ovf_still", 32'(FIFO_overflow), 32'd1);
    err_clr = 1'b1;
    step(1'b0, 1'b0, '0);
    err_clr = 1'b0;
    chk("err.ovf_clr", 32'(FIFO_overflow), 32'd0);
    chk("err.unf_clr", 32'(FIFO_underflow), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
